e203_itcm_ram_ctrl: RTL and testbench

//  Request/response front end driving the 64-bit single-port ITCM SRAM macro (8192x64, byte write mask).

---
 rtl/e203_itcm_ram_ctrl.sv | 154 +++++++++++++++
 tb/tb_e203_itcm_ram_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_itcm_ram_ctrl.sv
// Valid/ready front end for the 8192x64 ITCM SRAM: 32-bit commands in, in-order 32-bit responses out.
// Optional light-sleep idle control is enabled by defining E203_ITCM_RAM_CTRL_LS_EN.
module e203_itcm_ram_ctrl #(
    parameter int AW       = 16,
    parameter int RAM_AW   = 13,
    parameter int RAM_DW   = 64,
    parameter int RAM_MW   = 8,
    parameter int IDLE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [AW-1:0]     cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_MW-1:0] ram_wem,
    output logic [RAM_DW-1:0] ram_din,
    input  logic [RAM_DW-1:0] ram_dout,
    output logic              ram_sd,
    output logic              ram_ds,
    output logic              ram_ls
);

    logic        iss_valid_r;
    logic        iss_err_r;
    logic        iss_half_r;
    logic        iss_read_r;
    logic [31:0] fifo_data_r [0:1];
    logic        fifo_err_r  [0:1];
    logic        wptr_r;
    logic        rptr_r;
    logic [1:0]  count_r;

    logic [2:0]  occ_s;
    logic        pop_s;
    logic        push_s;
    logic        room_s;
    logic        aligned_s;
    logic        accept_s;
    logic [31:0] push_data_s;

    assign occ_s     = {1'b0, count_r} + {2'b00, iss_valid_r};
    assign rsp_valid = (count_r != 2'd0);
    assign pop_s     = rsp_valid & rsp_ready;
    assign push_s    = iss_valid_r;
    // A pop this cycle frees a slot for a command accepted in the same cycle.
    assign room_s    = ((occ_s - {2'b00, pop_s}) < 3'd2);
    assign aligned_s = (cmd_addr[1:0] == 2'b00);
    assign cmd_ready = ~rst & ~ram_ls & room_s;
    assign accept_s  = cmd_valid & cmd_ready;

    assign ram_cs   = accept_s & aligned_s;
    assign ram_we   = ~cmd_read;
    assign ram_addr = cmd_addr[AW-1:3];
    assign ram_wem  = cmd_addr[2] ? {cmd_wmask, 4'b0000} : {4'b0000, cmd_wmask};
    assign ram_din  = {cmd_wdata, cmd_wdata};
    assign ram_sd   = 1'b0;
    assign ram_ds   = 1'b0;

    assign rsp_rdata = rsp_valid ? fifo_data_r[rptr_r] : 32'd0;
    assign rsp_err   = rsp_valid ? fifo_err_r[rptr_r]  : 1'b0;

    // Select the addressed half of the RAM word; writes and errors return zero.
    always_comb begin
        push_data_s = 32'd0;
        if (iss_read_r && !iss_err_r) begin
            push_data_s = iss_half_r ? ram_dout[63:32] : ram_dout[31:0];
        end else begin
            push_data_s = 32'd0;
        end
    end

    // Issue stage: one command in flight while the RAM produces its read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_r <= 1'b0;
            iss_err_r   <= 1'b0;
            iss_half_r  <= 1'b0;
            iss_read_r  <= 1'b0;
        end else begin
            iss_valid_r <= accept_s;
            iss_err_r   <= accept_s & ~aligned_s;
            iss_half_r  <= cmd_addr[2];
            iss_read_r  <= cmd_read;
        end
    end

    // Two-entry response FIFO with wrapping 1-bit pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_data_r[0] <= 32'd0;
            fifo_data_r[1] <= 32'd0;
            fifo_err_r[0]  <= 1'b0;
            fifo_err_r[1]  <= 1'b0;
            wptr_r         <= 1'b0;
            rptr_r         <= 1'b0;
            count_r        <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_data_r[wptr_r] <= push_data_s;
                fifo_err_r[wptr_r]  <= iss_err_r;
                wptr_r              <= ~wptr_r;
            end
            if (pop_s) begin
                rptr_r <= ~rptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef E203_ITCM_RAM_CTRL_LS_EN
    localparam int CW = $clog2(IDLE_CYC + 1);
    localparam logic [CW-1:0] IDLE_MAX = CW'(IDLE_CYC);

    logic [CW-1:0] idle_cnt_r;
    logic          ram_ls_r;

    assign ram_ls = ram_ls_r;

    // Idle counter and light-sleep flag; a command while asleep spends one cycle waking.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_r <= {CW{1'b0}};
            ram_ls_r   <= 1'b0;
        end else if (ram_ls_r && cmd_valid) begin
            idle_cnt_r <= {CW{1'b0}};
            ram_ls_r   <= 1'b0;
        end else if (cmd_valid || (occ_s != 3'd0)) begin
            idle_cnt_r <= {CW{1'b0}};
        end else if (idle_cnt_r < IDLE_MAX) begin
            idle_cnt_r <= idle_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (idle_cnt_r == IDLE_MAX - {{(CW-1){1'b0}}, 1'b1}) begin
                ram_ls_r <= 1'b1;
            end
        end
    end
`else
    assign ram_ls = 1'b0;
`endif

endmodule

// File: tb/tb_e203_itcm_ram_ctrl.sv
// Directed self-checking bench for e203_itcm_ram_ctrl with a behavioural 8192x64 RAM model.
// Light-sleep checks follow E203_ITCM_RAM_CTRL_LS_EN.
module tb_e203_itcm_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_cs;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wem;
    logic [63:0] ram_din;
    logic [63:0] ram_dout;
    logic        ram_sd;
    logic        ram_ds;
    logic        ram_ls;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int cs_cnt    = 0;

    int          acc_q[$];
    int          rc_q[$];
    logic [31:0] rd_q[$];
    logic        er_q[$];

    logic [63:0] mem [0:8191];

    e203_itcm_ram_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_sd(ram_sd), .ram_ds(ram_ds), .ram_ls(ram_ls)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM macro model: byte-masked write, registered read.
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 8; b++) begin
                    if (ram_wem[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
                end
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    // Handshake monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (ram_cs) cs_cnt++;
        if (rsp_valid && rsp_ready) begin
            rd_q.push_back(rsp_rdata);
            er_q.push_back(rsp_err);
            rc_q.push_back(cyc);
        end
    end

    task automatic clear_q();
        acc_q.delete(); rc_q.delete(); rd_q.delete(); er_q.delete();
    endtask

    task automatic send(input logic rd, input logic [15:0] a, input logic [31:0] wd, input logic [3:0] wm);
        logic got;
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            got = cmd_ready;
            @(posedge clk); #1;
            if (got) break;
        end
        total_cnt++;
        if (!got) $display("FAIL send_timeout: addr %h not accepted got 0 want 1", a);
        else pass_cnt++;
    endtask

    task automatic wait_rsp(input int n);
        cmd_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rd_q.size() >= n) break;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (rd_q.size() < n) $display("FAIL rsp_timeout: got %0d responses want %0d", rd_q.size(), n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 16'h0000;
        cmd_wdata = 32'd0; cmd_wmask = 4'd0; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({cmd_ready, ram_cs, rsp_valid, rsp_err, ram_ls} !== 5'b00000 || rsp_rdata !== 32'd0)
                $display("FAIL reset_outputs: got rdy/cs/vld/err/ls %b%b%b%b%b rdata %h want 00000 0",
                         cmd_ready, ram_cs, rsp_valid, rsp_err, ram_ls, rsp_rdata);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_q();
        @(negedge clk);
        total_cnt++;
        if ({cmd_ready, ram_cs} !== 2'b11)
            $display("FAIL reset_first_accept: got rdy/cs %b%b want 11", cmd_ready, ram_cs);
        else pass_cnt++;
        @(posedge clk); #1;
        wait_rsp(1);
        total_cnt++;
        if (rd_q.size() != 1 || rd_q[0] !== 32'h1000_0000)
            $display("FAIL reset_first_data: got %h want 10000000", (rd_q.size() > 0) ? rd_q[0] : 32'hx);
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        clear_q();
        cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 16'h0104; cmd_wdata = 32'hA5A5_1234; cmd_wmask = 4'b0011;
        @(negedge clk);
        total_cnt++;
        if ({cmd_ready, ram_cs, ram_we} !== 3'b111 || ram_addr !== 13'h020 || ram_wem !== 8'h30 ||
            ram_din !== 64'hA5A5_1234_A5A5_1234)
            $display("FAIL write_ram_ctrl: got rdy/cs/we %b%b%b addr %h wem %h din %h want 111 020 30 a5a51234a5a51234",
                     cmd_ready, ram_cs, ram_we, ram_addr, ram_wem, ram_din);
        else pass_cnt++;
        @(posedge clk); #1;
        send(1'b1, 16'h0104, 32'd0, 4'd0);
        wait_rsp(2);
        total_cnt++;
        if (rd_q.size() != 2 || rd_q[0] !== 32'd0 || er_q[0] !== 1'b0)
            $display("FAIL write_rsp: got %h err %b want 00000000 err 0", rd_q[0], er_q[0]);
        else pass_cnt++;
        total_cnt++;
        if (rd_q.size() != 2 || rd_q[1] !== 32'h2000_1234 || er_q[1] !== 1'b0)
            $display("FAIL read_back: got %h err %b want 20001234 err 0", rd_q[1], er_q[1]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [0:7];
        exp = '{32'h1000_0000, 32'h2000_0000, 32'h1000_0001, 32'h2000_0001,
                32'h1000_0002, 32'h2000_0002, 32'h1000_0003, 32'h2000_0003};
        clear_q();
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) send(1'b1, 16'(k * 4), 32'd0, 4'd0);
        wait_rsp(8);
        total_cnt++;
        if (acc_q.size() != 8 || (acc_q[7] - acc_q[0]) != 7)
            $display("FAIL b2b_rate: got %0d accepts span %0d want 8 span 7", acc_q.size(),
                     (acc_q.size() == 8) ? acc_q[7] - acc_q[0] : -1);
        else pass_cnt++;
        total_cnt++;
        if (rc_q.size() < 1 || rc_q[0] != acc_q[0] + 2)
            $display("FAIL b2b_latency: got %0d want %0d", (rc_q.size() > 0) ? rc_q[0] - acc_q[0] : -1, 2);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            total_cnt++;
            if (rd_q.size() != 8 || rd_q[k] !== exp[k] || er_q[k] !== 1'b0)
                $display("FAIL b2b_data%0d: got %h want %h", k, rd_q[k], exp[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        clear_q();
        rsp_ready = 1'b0;
        send(1'b1, 16'h0040, 32'd0, 4'd0);
        send(1'b1, 16'h0048, 32'd0, 4'd0);
        cmd_addr = 16'h004C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({cmd_ready, ram_cs} !== 2'b00)
                $display("FAIL bp_stall%0d: got rdy/cs %b%b want 00", i, cmd_ready, ram_cs);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        total_cnt++;
        if (acc_q.size() != 2 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h1000_0008)
            $display("FAIL bp_hold: got acc %0d vld %b rdata %h want 2 1 10000008", acc_q.size(), rsp_valid, rsp_rdata);
        else pass_cnt++;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({cmd_ready, ram_cs, rsp_valid} !== 3'b111)
            $display("FAIL bp_release: got rdy/cs/vld %b%b%b want 111", cmd_ready, ram_cs, rsp_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        wait_rsp(3);
        total_cnt++;
        if (acc_q.size() != 3 || rc_q.size() < 1 || acc_q[2] != rc_q[0])
            $display("FAIL bp_same_cycle: got accepts %0d want third accept on first pop", acc_q.size());
        else pass_cnt++;
        total_cnt++;
        if (rd_q.size() != 3 || rd_q[0] !== 32'h1000_0008 || rd_q[1] !== 32'h1000_0009 || rd_q[2] !== 32'h2000_0009)
            $display("FAIL bp_data: got %h %h %h want 10000008 10000009 20000009", rd_q[0], rd_q[1], rd_q[2]);
        else pass_cnt++;
    endtask

    task automatic test_misaligned();
        int cs0;
        clear_q();
        rsp_ready = 1'b1;
        cs0 = cs_cnt;
        send(1'b1, 16'h0010, 32'd0, 4'd0);
        send(1'b1, 16'h0006, 32'd0, 4'd0);
        send(1'b1, 16'h0018, 32'd0, 4'd0);
        wait_rsp(3);
        total_cnt++;
        if (cs_cnt - cs0 != 2 || acc_q.size() != 3)
            $display("FAIL mis_cs: got cs %0d accepts %0d want 2 3", cs_cnt - cs0, acc_q.size());
        else pass_cnt++;
        total_cnt++;
        if (rd_q.size() != 3 || rd_q[0] !== 32'h1000_0002 || er_q[0] !== 1'b0 || rd_q[1] !== 32'd0 ||
            er_q[1] !== 1'b1 || rd_q[2] !== 32'h1000_0003 || er_q[2] !== 1'b0)
            $display("FAIL mis_order: got %h/%b %h/%b %h/%b want 10000002/0 00000000/1 10000003/0",
                     rd_q[0], er_q[0], rd_q[1], er_q[1], rd_q[2], er_q[2]);
        else pass_cnt++;
    endtask

    task automatic test_reset_flush();
        rsp_ready = 1'b0;
        send(1'b1, 16'h0000, 32'd0, 4'd0);
        send(1'b1, 16'h0008, 32'd0, 4'd0);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_q();
        rsp_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        total_cnt++;
        if (rd_q.size() != 0 || rsp_valid !== 1'b0)
            $display("FAIL flush: got %0d responses vld %b want 0 0", rd_q.size(), rsp_valid);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_light_sleep();
        int n;
        clear_q();
        send(1'b1, 16'h0000, 32'd0, 4'd0);
        wait_rsp(1);
        clear_q();
`ifdef E203_ITCM_RAM_CTRL_LS_EN
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ram_ls) break;
            n++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (ram_ls !== 1'b1 || n < 14)
            $display("FAIL ls_enter: got ls %b after %0d cycles want 1 after >=14", ram_ls, n);
        else pass_cnt++;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 16'h0000;
        @(negedge clk);
        total_cnt++;
        if ({ram_ls, cmd_ready, ram_cs} !== 3'b100)
            $display("FAIL ls_wake: got ls/rdy/cs %b%b%b want 100", ram_ls, cmd_ready, ram_cs);
        else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        total_cnt++;
        if ({ram_ls, cmd_ready, ram_cs} !== 3'b011)
            $display("FAIL ls_accept: got ls/rdy/cs %b%b%b want 011", ram_ls, cmd_ready, ram_cs);
        else pass_cnt++;
        @(posedge clk); #1;
`else
        n = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (ram_ls !== 1'b0) n++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (n != 0) $display("FAIL ls_off: got ram_ls=1 in %0d cycles want 0", n);
        else pass_cnt++;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 16'h0000;
        @(negedge clk);
        total_cnt++;
        if ({cmd_ready, ram_cs} !== 2'b11)
            $display("FAIL ls_off_accept: got rdy/cs %b%b want 11", cmd_ready, ram_cs);
        else pass_cnt++;
        @(posedge clk); #1;
`endif
        wait_rsp(1);
        total_cnt++;
        if (rd_q.size() != 1 || rd_q[0] !== 32'h1000_0000)
            $display("FAIL ls_data: got %h want 10000000", (rd_q.size() > 0) ? rd_q[0] : 32'hx);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = {32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
        ram_dout = 64'd0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_misaligned();
        test_reset_flush();
        test_light_sleep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
